// File: rtl/ram_sp_arbiter.sv
// Two-requester round-robin arbiter with bounded lock in front of one single-port RAM.
// Read returns are tagged through a short pipe and steered back to the issuing side.
module ram_sp_arbiter #(
  parameter int unsigned DW       = 8,
  parameter int unsigned AW       = 6,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_lock,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_lock,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam int unsigned CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t        state, state_nx;
  logic          ptr, ptr_nx;       // 0: A wins a tie, 1: B wins a tie
  logic [CW-1:0] cnt, cnt_nx;
  logic          tag_v, tag_id;     // read issued last cycle, and by which side
  logic          rd_issue;

  // Grant selection: the owner has absolute priority, otherwise round-robin on ties
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    case (state)
      OWN_A: begin
        a_gnt = a_req;
        b_gnt = ~a_req & b_req;
      end
      OWN_B: begin
        b_gnt = b_req;
        a_gnt = ~b_req & a_req;
      end
      default: begin
        if (a_req && b_req) begin
          a_gnt = ~ptr;
          b_gnt = ptr;
        end else begin
          a_gnt = a_req;
          b_gnt = b_req;
        end
      end
    endcase
  end

  // RAM port mux: idle cycles drive zeros so the RAM sees no stray writes
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (a_gnt) begin
      ram_we   = a_we;
      ram_addr = a_addr;
      ram_din  = a_wdata;
    end else if (b_gnt) begin
      ram_we   = b_we;
      ram_addr = b_addr;
      ram_din  = b_wdata;
    end
  end

  assign rd_issue = (a_gnt & ~a_we) | (b_gnt & ~b_we);

  // Ownership / round-robin next-state logic
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    case (state)
      OWN_A: begin
        if (a_req && a_lock && (cnt + CW'(1)) != CW'(MAX_LOCK)) begin
          cnt_nx = cnt + CW'(1);
        end else begin
          state_nx = IDLE;
          ptr_nx   = 1'b1;
          cnt_nx   = '0;
        end
      end
      OWN_B: begin
        if (b_req && b_lock && (cnt + CW'(1)) != CW'(MAX_LOCK)) begin
          cnt_nx = cnt + CW'(1);
        end else begin
          state_nx = IDLE;
          ptr_nx   = 1'b0;
          cnt_nx   = '0;
        end
      end
      default: begin
        if (a_gnt) begin
          if (a_lock) begin
            state_nx = OWN_A;
            cnt_nx   = CW'(1);
          end else begin
            ptr_nx = 1'b1;
          end
        end else if (b_gnt) begin
          if (b_lock) begin
            state_nx = OWN_B;
            cnt_nx   = CW'(1);
          end else begin
            ptr_nx = 1'b0;
          end
        end
      end
    endcase
  end

  // Arbitration state, read tag pipe and registered read returns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      cnt      <= '0;
      tag_v    <= 1'b0;
      tag_id   <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      cnt      <= cnt_nx;
      tag_v    <= rd_issue;
      tag_id   <= b_gnt;
      a_rvalid <= tag_v & ~tag_id;
      b_rvalid <= tag_v & tag_id;
      if (tag_v && !tag_id) a_rdata <= ram_dout;
      if (tag_v && tag_id)  b_rdata <= ram_dout;
    end
  end

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Bench for ram_sp_arbiter: directed scenarios plus random traffic against a
// transaction-level model (ownership tracking, memory array, return queue).
module tb_ram_sp_arbiter;

  localparam int MAXL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req = 0, a_lock = 0, a_we = 0;
  logic [5:0] a_addr = '0;
  logic [7:0] a_wdata = '0;
  logic       b_req = 0, b_lock = 0, b_we = 0;
  logic [5:0] b_addr = '0;
  logic [7:0] b_wdata = '0;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic       ram_we;
  logic [5:0] ram_addr;
  logic [7:0] ram_din, ram_dout;

  ram_sp_arbiter #(.DW(8), .AW(6), .MAX_LOCK(MAXL)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_lock(a_lock), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_lock(b_lock), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Single-port RAM: synchronous write and address capture, async read
  logic [7:0] mem [64] = '{default: 8'h00};
  logic [5:0] addr_q = '0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    addr_q <= ram_addr;
  end
  assign ram_dout = mem[addr_q];

  // Reference model state
  typedef struct { int due; int side; logic [7:0] data; } ret_t;
  ret_t       rq[$];
  logic [7:0] mm [64];
  int         owner, streak, first, cyc;
  logic [7:0] e_ard, e_brd;
  int         checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic ar, input logic br);
    logic [1:0] r;
    r = {br, ar};
    if (owner >= 0 && r[owner]) return owner;
    if (owner >= 0 && r[1-owner]) return 1 - owner;
    if (ar && br) return first;
    if (ar) return 0;
    if (br) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    rq.delete();
    owner = -1; streak = 0; first = 0;
    e_ard = '0; e_brd = '0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    a_req = 0; b_req = 0; a_lock = 0; b_lock = 0; a_we = 0; b_we = 0;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_a_rvalid", 32'(a_rvalid), 0);
    check("rst_b_rvalid", 32'(b_rvalid), 0);
    check("rst_a_rdata", 32'(a_rdata), 0);
    check("rst_b_rdata", 32'(b_rdata), 0);
    check("rst_gnt", 32'({a_gnt, b_gnt}), 0);
    check("rst_ram", 32'({ram_we, ram_addr, ram_din}), 0);
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    cyc += cycles + 1;
  endtask

  task automatic step(input logic ar, input logic al, input logic aw, input logic [5:0] aa,
                      input logic [7:0] ad, input logic br, input logic bl, input logic bw,
                      input logic [5:0] ba, input logic [7:0] bd);
    int g; logic e_arv, e_brv, ewe, lk; logic [5:0] ea; logic [7:0] ed; ret_t r;
    @(negedge clk);
    a_req = ar; a_lock = al; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_lock = bl; b_we = bw; b_addr = ba; b_wdata = bd;
    #1;
    e_arv = 0; e_brv = 0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      if (r.side == 0) begin e_arv = 1; e_ard = r.data; end
      else begin e_brv = 1; e_brd = r.data; end
    end
    check("a_rvalid", 32'(a_rvalid), 32'(e_arv));
    check("b_rvalid", 32'(b_rvalid), 32'(e_brv));
    check("a_rdata", 32'(a_rdata), 32'(e_ard));
    check("b_rdata", 32'(b_rdata), 32'(e_brd));
    g = model_grant(ar, br);
    check("a_gnt", 32'(a_gnt), 32'(g == 0));
    check("b_gnt", 32'(b_gnt), 32'(g == 1));
    ewe = 0; ea = '0; ed = '0; lk = 0;
    if (g == 0) begin ewe = aw; ea = aa; ed = ad; lk = al; end
    if (g == 1) begin ewe = bw; ea = ba; ed = bd; lk = bl; end
    check("ram_we", 32'(ram_we), 32'(ewe));
    check("ram_addr", 32'(ram_addr), 32'(ea));
    check("ram_din", 32'(ram_din), 32'(ed));
    if (g >= 0) begin
      if (ewe) mm[ea] = ed;
      else rq.push_back('{due: cyc + 2, side: g, data: mm[ea]});
    end
    // ownership bookkeeping
    if (owner >= 0) begin
      if (g == owner && lk && streak + 1 < MAXL) streak++;
      else begin first = 1 - owner; owner = -1; streak = 0; end
    end else if (g >= 0) begin
      if (lk) begin owner = g; streak = 1; end
      else first = 1 - g;
    end
    cyc++;
  endtask

  initial begin
    cyc = 0;
    for (int i = 0; i < 64; i++) mm[i] = 8'h00;
    model_reset();
    do_reset(2);

    // 1: A write then read of addr 5
    step(1, 0, 1, 6'd5, 8'h3C, 0, 0, 0, 0, 0);
    step(1, 0, 0, 6'd5, 8'h00, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t1_a_rdata", 32'(a_rdata), 32'h3C);
    check("t1_b_rvalid", 32'(b_rvalid), 0);

    // 2: both read every cycle, no lock
    do_reset(1);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 6'(i), 0, 1, 0, 0, 6'(i + 20), 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // 3: A writes 9, B reads 9 next cycle
    do_reset(1);
    step(1, 0, 1, 6'd9, 8'h11, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 6'd9, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t3_b_rdata", 32'(b_rdata), 32'h11);

    // 4: A locked continuously while B requests
    do_reset(1);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 6'(i), 0, 1, 0, 0, 6'(i), 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // 5: A drops req mid-lock, B takes the port that cycle
    do_reset(1);
    step(1, 1, 0, 6'd1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 6'd2, 0, 1, 0, 0, 6'd3, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0, 6'd4, 0);
    step(1, 0, 0, 6'd5, 0, 1, 0, 0, 6'd6, 0);
    step(1, 0, 0, 6'd7, 0, 1, 0, 0, 6'd8, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // 6: reset one cycle after a read grant drops the return
    step(1, 0, 0, 6'd5, 0, 0, 0, 0, 0, 0);
    do_reset(1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
           6'($urandom_range(0, 7)), 8'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
           6'($urandom_range(0, 7)), 8'($urandom));
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
